// File: rtl/aes_pkg.sv
// Shared AES constants: FIPS-197 forward S-box, its inverse, and substitution mode encoding.
package aes_pkg;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    typedef logic [0:255][7:0] sbox_table_t;

    localparam sbox_table_t SBOX_FWD = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // The inverse table is derived from the forward one so the two can never disagree.
    function automatic sbox_table_t invert_table(input sbox_table_t fwd);
        sbox_table_t inv;
        inv = '0;
        for (int i = 0; i < 256; i++) begin
            inv[fwd[i]] = 8'(i);
        end
        return inv;
    endfunction

    localparam sbox_table_t SBOX_INV = invert_table(SBOX_FWD);

endpackage

// File: rtl/sbox_byte.sv
// Combinational single-byte AES S-box lookup. Forward table only present when
// SUB_BYTES_FWD_EN is defined; otherwise every byte is inverse-substituted.
module sbox_byte
    import aes_pkg::*;
(
    input  logic       mode_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

`ifdef SUB_BYTES_FWD_EN
    assign data_o = (mode_i == MODE_FWD) ? SBOX_FWD[data_i] : SBOX_INV[data_i];
`else
    logic unused_mode;
    assign unused_mode = mode_i;
    assign data_o      = SBOX_INV[data_i];
`endif

endmodule

// File: rtl/sub_bytes_pipe.sv
// Two-stage valid/ready AES SubBytes/InvSubBytes unit over LANES bytes.
// Build macro SUB_BYTES_FWD_EN enables the forward direction (decrypt-only otherwise).
module sub_bytes_pipe
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 16,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [8*LANES-1:0] in_data,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam int unsigned DW = 8 * LANES;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_mode_q, s1_mode_d;
    logic [DW-1:0]    s1_data_q, s1_data_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s2_valid_q, s2_valid_d;
    logic [DW-1:0]    s2_data_q, s2_data_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic          s1_load;
    logic          s2_load;
    logic [DW-1:0] sub_data;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sbox_byte u_sbox (
            .mode_i (s1_mode_q),
            .data_i (s1_data_q[8*k +: 8]),
            .data_o (sub_data[8*k +: 8])
        );
    end

    // in_ready depends on out_ready only, never on in_valid.
    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !(s1_valid_q && s2_valid_q && !out_ready);
    assign s1_load  = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_data_d  = s1_data_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_tag_d   = s2_tag_q;

        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_data_d  = sub_data;
            s2_tag_d   = s1_tag_q;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end

        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_mode_d  = in_mode;
            s1_data_d  = in_data;
            s1_tag_d   = in_tag;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_data_q  <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s1_data_q  <= s1_data_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;
    assign busy      = s1_valid_q || s2_valid_q;

endmodule
